// File: rtl/proc_err_monitor.sv
// proc_err_monitor: conditions the raw reset for the RISC-V core (two-flop
// synchronizer plus a programmable hold stretch). It then watches the core
// status strobes and a retire-based watchdog. It latches a sticky error or
// clean-halt result and keeps cycle, retire and error-cycle counts for
// end-of-test checks.
module proc_err_monitor #(
  parameter int HOLD_CYCLES = 2,
  parameter int WDOG_CYCLES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             core_rst_n,
  input  logic             retire,
  input  logic             halt,
  input  logic             illegal_instr,
  input  logic             mem_misalign,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] err_cycle
);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_HOLD,
    ST_RUN,
    ST_ERROR,
    ST_HALTED
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYCLES - 1);

  localparam logic [1:0] CODE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CODE_MISALIGN = 2'd2;
  localparam logic [1:0] CODE_WDOG     = 2'd3;

  state_t     state;
  logic       sync1;
  logic       sync2;
  logic [3:0] hold_cnt;
  logic [7:0] wdog_cnt;
  logic       wdog_fire;

  // Saturating increment so long runs pin at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The watchdog fires on the WDOG_CYCLES-th consecutive cycle without a retire.
  assign wdog_fire = !retire && (wdog_cnt == WDOG_LAST);

  // Two-flop synchronizer for the release edge of the raw reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= 1'b1;
      sync2 <= sync1;
    end
  end

  // Control FSM with registered outputs and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RESET;
      hold_cnt     <= '0;
      wdog_cnt     <= '0;
      core_rst_n   <= 1'b0;
      err          <= 1'b0;
      err_code     <= '0;
      done         <= 1'b0;
      cycle_count  <= '0;
      retire_count <= '0;
      err_cycle    <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          // The edge on which the synchronized reset is first seen high
          // counts as the first hold cycle. As a result, core_rst_n
          // releases HOLD_CYCLES edges after the synchronizer output rises.
          if (sync2) begin
            if (HOLD_CYCLES == 1) begin
              state      <= ST_RUN;
              core_rst_n <= 1'b1;
            end else begin
              state    <= ST_HOLD;
              hold_cnt <= 4'd1;
            end
          end
        end

        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= ST_RUN;
            core_rst_n <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end

        ST_RUN: begin
          cycle_count <= sat_inc(cycle_count);
          if (retire) begin
            retire_count <= sat_inc(retire_count);
            wdog_cnt     <= '0;
          end else begin
            wdog_cnt <= wdog_cnt + 8'd1;
          end

          if (illegal_instr) begin
            state     <= ST_ERROR;
            err       <= 1'b1;
            err_code  <= CODE_ILLEGAL;
            err_cycle <= cycle_count;
          end else if (mem_misalign) begin
            state     <= ST_ERROR;
            err       <= 1'b1;
            err_code  <= CODE_MISALIGN;
            err_cycle <= cycle_count;
          end else if (wdog_fire) begin
            state     <= ST_ERROR;
            err       <= 1'b1;
            err_code  <= CODE_WDOG;
            err_cycle <= cycle_count;
          end else if (halt) begin
            state <= ST_HALTED;
            done  <= 1'b1;
          end
        end

        // ERROR and HALTED hold everything until the raw reset is asserted.
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_err_monitor.sv
// Directed bench for proc_err_monitor (HOLD_CYCLES=2, WDOG_CYCLES=8).
module tb_proc_err_monitor;

  logic        clk;
  logic        rst_n;
  logic        core_rst_n;
  logic        retire;
  logic        halt;
  logic        illegal_instr;
  logic        mem_misalign;
  logic        err;
  logic [1:0]  err_code;
  logic        done;
  logic [31:0] cycle_count;
  logic [31:0] retire_count;
  logic [31:0] err_cycle;

  int vectors;
  int miscompares;

  proc_err_monitor #(
    .HOLD_CYCLES(2),
    .WDOG_CYCLES(8),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .core_rst_n(core_rst_n),
    .retire(retire),
    .halt(halt),
    .illegal_instr(illegal_instr),
    .mem_misalign(mem_misalign),
    .err(err),
    .err_code(err_code),
    .done(done),
    .cycle_count(cycle_count),
    .retire_count(retire_count),
    .err_cycle(err_cycle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise rst_n mid-cycle (between E0 and E1) and check the 4-edge release.
  // If junk is set, illegal_instr is high during the HOLD phase and drops
  // just before the first RUN cycle.
  task automatic do_release(input bit junk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_e1_core_rst", core_rst_n, 0);
    if (junk) illegal_instr = 1'b1;
    tick();
    check("rel_e2_core_rst", core_rst_n, 0);
    tick();
    check("rel_e3_core_rst", core_rst_n, 0);
    tick();
    check("rel_e4_core_rst", core_rst_n, 1);
    check("rel_e4_cycles", cycle_count, 0);
    illegal_instr = 1'b0;
  endtask

  // Assert rst_n away from any clock edge and check the asynchronous clear.
  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    check({tag, "_core_rst"}, core_rst_n, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_code"}, err_code, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cycles"}, cycle_count, 0);
    check({tag, "_retires"}, retire_count, 0);
    check({tag, "_errcyc"}, err_cycle, 0);
    repeat (3) tick();
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst_n         = 1'b0;
    retire        = 1'b0;
    halt          = 1'b0;
    illegal_instr = 1'b0;
    mem_misalign  = 1'b0;

    // Reset state with rst_n held low for 3 cycles
    repeat (3) tick();
    check("rst_core_rst", core_rst_n, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    check("rst_done", done, 0);
    check("rst_cycles", cycle_count, 0);
    check("rst_retires", retire_count, 0);

    // Release with illegal_instr held high during HOLD, then a normal program
    do_release(1'b1);
    for (int c = 1; c <= 12; c++) begin
      retire = (c != 3 && c != 8);
      tick();
      if (c == 1) check("run_e5_cycles", cycle_count, 1);
      if (c == 1) check("hold_junk_err", err, 0);
    end
    retire = 1'b0;
    halt   = 1'b1;
    tick();
    halt = 1'b0;
    check("halt_done", done, 1);
    check("halt_err", err, 0);
    check("halt_code", err_code, 0);
    check("halt_retires", retire_count, 10);
    check("halt_cycles", cycle_count, 13);
    retire        = 1'b1;
    illegal_instr = 1'b1;
    repeat (5) tick();
    retire        = 1'b0;
    illegal_instr = 1'b0;
    check("halted_frozen_cycles", cycle_count, 13);
    check("halted_frozen_retires", retire_count, 10);
    check("halted_done", done, 1);
    check("halted_err", err, 0);

    // Watchdog with no retire at all
    async_reset("rst_a");
    do_release(1'b0);
    for (int c = 1; c <= 7; c++) tick();
    check("wdog_pre_err", err, 0);
    tick();
    check("wdog_err", err, 1);
    check("wdog_code", err_code, 3);
    check("wdog_errcyc", err_cycle, 7);
    check("wdog_cycles", cycle_count, 8);
    illegal_instr = 1'b1;
    mem_misalign  = 1'b1;
    retire        = 1'b1;
    repeat (2) tick();
    illegal_instr = 1'b0;
    mem_misalign  = 1'b0;
    retire        = 1'b0;
    check("err_sticky_code", err_code, 3);
    check("err_sticky_errcyc", err_cycle, 7);
    check("err_frozen_cycles", cycle_count, 8);
    check("err_frozen_retires", retire_count, 0);

    // Reset while err=1, then the full release sequence again
    async_reset("rst_b");
    do_release(1'b0);

    // Watchdog restarted by a retire in RUN cycle 7
    for (int c = 1; c <= 14; c++) begin
      retire = (c == 7);
      tick();
    end
    retire = 1'b0;
    check("wdog2_pre_err", err, 0);
    tick();
    check("wdog2_err", err, 1);
    check("wdog2_code", err_code, 3);
    check("wdog2_errcyc", err_cycle, 14);
    check("wdog2_retires", retire_count, 1);

    // Simultaneous illegal, misalign and halt in RUN cycle 5
    async_reset("rst_c");
    do_release(1'b0);
    for (int c = 1; c <= 4; c++) begin
      retire = 1'b1;
      tick();
    end
    retire        = 1'b0;
    illegal_instr = 1'b1;
    mem_misalign  = 1'b1;
    halt          = 1'b1;
    tick();
    illegal_instr = 1'b0;
    mem_misalign  = 1'b0;
    halt          = 1'b0;
    check("simul_err", err, 1);
    check("simul_code", err_code, 1);
    check("simul_done", done, 0);
    check("simul_errcyc", err_cycle, 4);

    // Same, without illegal_instr; the retire in the error cycle still counts
    async_reset("rst_d");
    do_release(1'b0);
    for (int c = 1; c <= 4; c++) begin
      retire = 1'b1;
      tick();
    end
    mem_misalign = 1'b1;
    halt         = 1'b1;
    tick();
    retire       = 1'b0;
    mem_misalign = 1'b0;
    halt         = 1'b0;
    check("mis_err", err, 1);
    check("mis_code", err_code, 2);
    check("mis_done", done, 0);
    check("mis_errcyc", err_cycle, 4);
    check("mis_retires", retire_count, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
